// File: rtl/l3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l3_pkg
//  Description : Shared definitions for the lab-3 sequencer. Holds the opcode
//                constants, the sequencer state encoding, the instruction
//                field slice positions and small decode helpers.
//                Instruction word layout (bit 0 is the MSB):
//                  opcode[0:2], rx[3:4], ry[5:6], imm[7:10]
//  Revision    : 1.0 - initial release
// ============================================================================
package l3_pkg;

  // Opcodes
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_DISP = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;
  localparam logic [2:0] OP_SUBI = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  // Instruction field slice positions
  localparam int INSTR_W = 11;
  localparam int OPC_HI  = 0;
  localparam int OPC_LO  = 2;
  localparam int RX_HI   = 3;
  localparam int RX_LO   = 4;
  localparam int RY_HI   = 5;
  localparam int RY_LO   = 6;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 10;

  // Sequencer states. WAIT_STEP is only reachable in single-step builds.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_GAP       = 3'd2,
    ST_DONE      = 3'd3,
    ST_WAIT_STEP = 3'd4
  } seq_state_e;

  function automatic logic [2:0] instr_opcode(input logic [0:10] w);
    return w[OPC_HI:OPC_LO];
  endfunction

  // Load and display use the short exec window; everything else the long one.
  function automatic logic is_short_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_DISP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/l3_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : l3_prog_mem
//  Description : DEPTH x 11-bit program buffer. Synchronous write,
//                combinational read. Contents are not reset.
//  Ports       : clk      - system clock, rising edge
//                we_i     - write enable
//                waddr_i  - write address
//                wdata_i  - write data (instruction word)
//                raddr_i  - read address
//                rdata_o  - read data, combinational from raddr_i
//  Revision    : 1.0 - initial release
// ============================================================================
module l3_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [0:10]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [0:10]   rdata_o
);

  logic [0:10] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/l3_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : l3_sequencer
//  Description : Program sequencer for the lab-3 datapath. Replays a small
//                program buffer into l3_SM by driving exec/instr, holding each
//                instruction for its opcode-dependent number of cycles and
//                inserting an idle gap between instructions. Opcode 101 is a
//                HALT that ends the program without raising exec.
//  Optional    : SEQ_SINGLE_STEP_EN - adds input `step` and a WAIT_STEP state;
//                after each gap the FSM waits for a step pulse before issuing
//                the next instruction.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start, abort        - run control (abort has priority)
//                step                - single-step advance (optional build)
//                prog_we/addr/data   - program buffer write port
//                prog_len            - instruction count, latched on start
//                exec, instr         - strobe and word to l3_SM
//                pc                  - index of current instruction
//                busy                - high in ISSUE/GAP (and WAIT_STEP)
//                done                - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module l3_sequencer
  import l3_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int LOAD_CYCLES = 3,
  parameter int ALU_CYCLES  = 5,
  parameter int GAP_CYCLES  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [0:10]   prog_data,
  input  logic [AW:0]   prog_len,
  output logic          exec,
  output logic [0:10]   instr,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  // Counter holds "cycles remaining minus one", so it only needs to reach
  // the largest window length.
  localparam int c_max_a = (LOAD_CYCLES > ALU_CYCLES) ? LOAD_CYCLES : ALU_CYCLES;
  localparam int c_max   = (c_max_a > GAP_CYCLES) ? c_max_a : GAP_CYCLES;
  localparam int c_cw    = $clog2(c_max + 1);

  localparam logic [c_cw-1:0] c_load_last = c_cw'(LOAD_CYCLES - 1);
  localparam logic [c_cw-1:0] c_alu_last  = c_cw'(ALU_CYCLES - 1);
  localparam logic [c_cw-1:0] c_gap_last  = c_cw'(GAP_CYCLES - 1);
  localparam logic [AW:0]     c_depth     = (AW + 1)'(DEPTH);

  seq_state_e      state_q, state_d;
  logic [c_cw-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW:0]     len_q, len_d;
  logic [0:10]     instr_q, instr_d;
  logic            exec_q, exec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            w_issue;
  logic [AW-1:0]   w_issue_pc;
  logic [0:10]     w_rd_data;
  logic [AW:0]     w_len_clamped;
  logic [AW:0]     w_pc_next_ext;
  logic [AW-1:0]   w_pc_inc;

  // Buffer writes are locked out while a program is running so the word
  // being executed can never change under l3_SM.
  l3_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (prog_we && !busy_q),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (w_issue_pc),
    .rdata_o (w_rd_data)
  );

  assign w_len_clamped = (prog_len > c_depth) ? c_depth : prog_len;
  assign w_pc_next_ext = (AW + 1)'(pc_q) + (AW + 1)'(1);
  assign w_pc_inc      = pc_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    len_d      = len_q;
    instr_d    = instr_q;
    w_issue    = 1'b0;
    w_issue_pc = pc_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d = w_len_clamped;
            if (w_len_clamped == '0) begin
              state_d = ST_DONE;
            end else begin
              w_issue    = 1'b1;
              w_issue_pc = '0;
            end
          end
        end
        ST_ISSUE: begin
          if (instr_opcode(instr_q) == OP_HALT) begin
            state_d = ST_DONE;
          end else if (cnt_q == '0) begin
            state_d = ST_GAP;
            cnt_d   = c_gap_last;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (w_pc_next_ext >= len_q) begin
            state_d = ST_DONE;
          end else begin
`ifdef SEQ_SINGLE_STEP_EN
            state_d = ST_WAIT_STEP;
`else
            w_issue    = 1'b1;
            w_issue_pc = w_pc_inc;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        ST_WAIT_STEP: begin
          if (step) begin
            w_issue    = 1'b1;
            w_issue_pc = w_pc_inc;
          end
        end
`endif
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Common entry into ISSUE: latch the word and load its hold window.
    if (w_issue) begin
      state_d = ST_ISSUE;
      pc_d    = w_issue_pc;
      instr_d = w_rd_data;
      cnt_d   = is_short_op(instr_opcode(w_rd_data)) ? c_load_last : c_alu_last;
    end

    // Outputs are registered alongside the state, so they are decoded from
    // the next state. A HALT word sits in ISSUE for one cycle with exec low.
    exec_d = (state_d == ST_ISSUE) && (instr_opcode(instr_d) != OP_HALT);
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_GAP) || (state_d == ST_WAIT_STEP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      exec_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      exec_q  <= exec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign exec  = exec_q;
  assign instr = instr_q;
  assign pc    = pc_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire
